picorv32_mem_model: RTL and testbench

//   Parametrised slave for the picorv32 native memory interface (valid/ready, byte wstrb).

---
 rtl/picorv32_mem_pkg.sv | 22 ++
 rtl/mem_wait_lfsr.sv | 25 ++
 rtl/picorv32_mem_model.sv | 173 +++++++++++++++++
 tb/tb_picorv32_mem_model.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_mem_pkg.sv
// Shared definitions for the picorv32 native-interface memory model.
//   mem_state_e : request FSM states (IDLE -> WAIT -> RESP)
//   MMIO_*      : register offsets inside the 16-byte MMIO page
//   PASS_CODE   : value written to TEST that marks a passing run
//   LFSR_TAPS   : Galois feedback mask for taps 16,14,13,11 (right-shifting form)
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam logic [3:0]  MMIO_CON  = 4'h0;
  localparam logic [3:0]  MMIO_TEST = 4'h4;
  localparam logic [3:0]  MMIO_CYC  = 4'h8;

  localparam logic [31:0] PASS_CODE = 32'd1;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mem_wait_lfsr.sv
// 16-bit Galois LFSR used to draw pseudo-random wait-state counts.
//   clk     in  clock
//   reset   in  synchronous active-high, loads SEED
//   advance in  step the sequence by one position
//   value   out current LFSR state
module mem_wait_lfsr
  import picorv32_mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else if (advance) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/picorv32_mem_model.sv
// Slave for the picorv32 native memory interface: word RAM with optional
// hex preload, fixed or LFSR-random wait states, and a 16-byte MMIO page
// (console byte, sticky test pass/fail, free-running cycle counter).
//   clk, reset            clock / synchronous active-high reset
//   mem_valid..mem_wstrb  CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata  one-cycle acknowledge and read data
//   con_data, con_valid   last console byte / pulse on console write ack
//   test_done, test_pass  sticky result of the first TEST write
//   bus_err               sticky flag for any unmapped access
module picorv32_mem_model
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter string       INIT_FILE   = "",
  parameter int unsigned WAIT_MODE   = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  output logic        test_done,
  output logic        test_pass,
  output logic        bus_err
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

  mem_state_e    state_q, state_d;
  logic [15:0]   wait_q, wait_load;
  logic [31:0]   req_addr, req_wdata;
  logic [3:0]    req_wstrb;
  logic [31:0]   ram [MEM_WORDS];
  logic [31:0]   cycles;
  logic [15:0]   lfsr;
  logic          accept, do_access, is_write, ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [3:0]    mmio_off;
  logic          unused_ok;

  assign unused_ok = ^{mem_instr, req_addr[1:0]};

  mem_wait_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .value   (lfsr)
  );

  always_comb begin
    if (WAIT_MODE == 1) wait_load = 16'(32'(lfsr) % (WAIT_STATES + 32'd1));
    else                wait_load = 16'(WAIT_STATES);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state (RESP ignores mem_valid, giving the CPU a cycle to drop it)
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_valid) state_d = ST_WAIT;
      ST_WAIT: if (wait_q == '0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept    = (state_q == ST_IDLE) && mem_valid;
    do_access = (state_q == ST_WAIT) && (wait_q == '0);
  end

  // Address decode works on the latched request so a misbehaving CPU
  // that changes mem_addr mid-transaction cannot corrupt the access.
  always_comb begin
    is_write = |req_wstrb;
    ram_hit  = ({1'b0, req_addr} < RAM_BYTES);
    mmio_hit = !ram_hit && (req_addr[31:4] == MMIO_BASE[31:4]);
    mmio_off = {req_addr[3:2], 2'b00};
    ram_idx  = req_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      wait_q    <= '0;
    end else if (accept) begin
      req_addr  <= mem_addr;
      req_wdata <= mem_wdata;
      req_wstrb <= mem_wstrb;
      wait_q    <= wait_load;
    end else if ((state_q == ST_WAIT) && (wait_q != '0)) begin
      wait_q <= wait_q - 16'd1;
    end
  end

  // RAM is never reset; reset still blocks a commit that lands on the reset edge.
  always_ff @(posedge clk) begin
    if (!reset && do_access && ram_hit && is_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_wstrb[b]) ram[ram_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      con_data  <= '0;
      con_valid <= 1'b0;
      test_done <= 1'b0;
      test_pass <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      mem_ready <= do_access;
      con_valid <= 1'b0;
      if (do_access) begin
        if (ram_hit) begin
          mem_rdata <= ram[ram_idx];
        end else if (mmio_hit) begin
          case (mmio_off)
            MMIO_CON: begin
              mem_rdata <= '0;
              if (is_write) begin
                con_valid <= 1'b1;
                if (req_wstrb[0]) con_data <= req_wdata[7:0];
              end
            end
            MMIO_TEST: begin
              mem_rdata <= {30'b0, test_pass, test_done};
              if (is_write && !test_done) begin
                test_done <= 1'b1;
                test_pass <= (req_wdata == PASS_CODE);
              end
            end
            MMIO_CYC: mem_rdata <= cycles;
            default: begin
              mem_rdata <= '0;
              bus_err   <= 1'b1;
            end
          endcase
        end else begin
          mem_rdata <= '0;
          bus_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Bench for picorv32_mem_model: three instances (no wait, fixed 3 waits,
// random 0..3 waits) driven by directed transactions, checked each cycle
// against a transaction-level model, plus literal pins.
module tb_picorv32_mem_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst    [3];
  logic        valid  [3];
  logic        instr  [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  wstrb  [3];
  logic        ready  [3];
  logic [31:0] rdata  [3];
  logic [7:0]  cdata  [3];
  logic        cvalid [3];
  logic        tdone  [3];
  logic        tpass  [3];
  logic        berr   [3];

  picorv32_mem_model u_d0 (
    .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .con_data(cdata[0]), .con_valid(cvalid[0]),
    .test_done(tdone[0]), .test_pass(tpass[0]), .bus_err(berr[0]));

  picorv32_mem_model #(.WAIT_STATES(3)) u_d1 (
    .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .con_data(cdata[1]), .con_valid(cvalid[1]),
    .test_done(tdone[1]), .test_pass(tpass[1]), .bus_err(berr[1]));

  picorv32_mem_model #(.WAIT_MODE(1), .WAIT_STATES(3), .LFSR_SEED(16'hACE1)) u_d2 (
    .clk(clk), .reset(rst[2]), .mem_valid(valid[2]), .mem_instr(instr[2]),
    .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
    .mem_ready(ready[2]), .mem_rdata(rdata[2]), .con_data(cdata[2]), .con_valid(cvalid[2]),
    .test_done(tdone[2]), .test_pass(tpass[2]), .bus_err(berr[2]));

  // ---------------- model state ----------------
  logic [31:0] m_mem  [3][256];
  logic        m_vld  [3][256];
  logic        busy   [3];
  int          ack_cyc[3];
  logic [31:0] exp_rd [3];
  logic        exp_chk[3];
  logic        exp_con[3];
  logic        p_done [3], p_pass [3], p_err [3];
  logic [7:0]  p_con  [3];
  logic        m_done [3], m_pass [3], m_err [3];
  logic [7:0]  m_con  [3];
  logic        rst_q  [3];
  int          rst_cyc[3];
  logic [15:0] m_lfsr = 16'hACE1;
  logic        chk_en = 1'b0;
  int          con_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      rst_q[d] <= rst[d];
      if (rst[d]) rst_cyc[d] <= cyc + 1;
    end
  end

  always @(negedge clk) if (cvalid[0] === 1'b1) con_pulses++;

  // Per-cycle compare against the model.
  always @(negedge clk) begin : cmp
    logic ack_now;
    for (int d = 0; d < 3; d++) begin
      if (rst_q[d]) begin
        m_done[d] = 1'b0; m_pass[d] = 1'b0; m_err[d] = 1'b0; m_con[d] = 8'h00;
      end
      if (chk_en) begin
        ack_now = busy[d] && (cyc == ack_cyc[d]);
        if (ack_now) begin
          m_done[d] = p_done[d]; m_pass[d] = p_pass[d];
          m_err[d]  = p_err[d];  m_con[d]  = p_con[d];
        end
        check($sformatf("d%0d mem_ready", d), 32'(ready[d]), 32'(ack_now));
        if (ack_now && exp_chk[d]) check($sformatf("d%0d mem_rdata", d), rdata[d], exp_rd[d]);
        check($sformatf("d%0d con_valid", d), 32'(cvalid[d]), 32'(ack_now && exp_con[d]));
        check($sformatf("d%0d con_data", d),  32'(cdata[d]),  32'(m_con[d]));
        check($sformatf("d%0d test_done", d), 32'(tdone[d]),  32'(m_done[d]));
        check($sformatf("d%0d test_pass", d), 32'(tpass[d]),  32'(m_pass[d]));
        check($sformatf("d%0d bus_err", d),   32'(berr[d]),   32'(m_err[d]));
      end
    end
  end

  // One complete CPU transaction; model expectations are set up before driving.
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output int lat);
    int   extra;
    int   t0;
    logic wr;
    logic got;
    logic [7:0] w;
    wr = |ws;
    w  = a[9:2];
    @(posedge clk); #1;
    t0 = cyc;
    if (d == 2) begin
      extra  = int'(m_lfsr % 16'd4);
      m_lfsr = lfsr_step(m_lfsr);
    end else begin
      extra = (d == 0) ? 0 : 3;
    end
    ack_cyc[d] = t0 + 2 + extra;
    exp_con[d] = 1'b0; exp_chk[d] = 1'b1;
    p_done[d] = m_done[d]; p_pass[d] = m_pass[d]; p_err[d] = m_err[d]; p_con[d] = m_con[d];
    if (a < 32'h400) begin
      exp_rd[d]  = m_mem[d][w];
      exp_chk[d] = m_vld[d][w];
      for (int b = 0; b < 4; b++) if (ws[b]) m_mem[d][w][8*b +: 8] = wd[8*b +: 8];
      if (ws == 4'hF) m_vld[d][w] = 1'b1;
    end else if (a[31:4] == 28'h100_0000) begin
      case (a[3:2])
        2'd0: begin
          exp_rd[d] = 32'h0;
          if (wr) begin exp_con[d] = 1'b1; if (ws[0]) p_con[d] = wd[7:0]; end
        end
        2'd1: begin
          exp_rd[d] = {30'b0, m_pass[d], m_done[d]};
          if (wr && !m_done[d]) begin p_done[d] = 1'b1; p_pass[d] = (wd == 32'd1); end
        end
        2'd2: exp_rd[d] = 32'(ack_cyc[d] - 1 - rst_cyc[d]);
        default: begin exp_rd[d] = 32'h0; p_err[d] = 1'b1; end
      endcase
    end else begin
      exp_rd[d] = 32'h0; p_err[d] = 1'b1;
    end
    busy[d]  = 1'b1;
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) got = 1'b1;
    end
    rd  = rdata[d];
    lat = cyc - t0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL d%0d timeout: no mem_ready within 30 cycles, addr %h", d, a);
      lat = -1;
    end
    @(posedge clk); #1;
    valid[d] = 1'b0; wstrb[d] = 4'h0;
    busy[d]  = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, c1, c2;
    int          lat;
    int          hist [6];
    logic [31:0] a, wd;
    logic [3:0]  ws;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; valid[d] = 1'b0; instr[d] = 1'b0; addr[d] = '0;
      wdata[d] = '0; wstrb[d] = '0; busy[d] = 1'b0; ack_cyc[d] = 0;
      exp_con[d] = 1'b0; exp_chk[d] = 1'b0; exp_rd[d] = '0;
      for (int w = 0; w < 256; w++) begin m_vld[d][w] = 1'b0; m_mem[d][w] = '0; end
    end
    for (int k = 0; k < 6; k++) hist[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset mem_ready", 32'(ready[0]), 32'd0);
    check("reset mem_rdata", rdata[0], 32'd0);
    check("reset con_data",  32'(cdata[0]), 32'd0);
    check("reset con_valid", 32'(cvalid[0]), 32'd0);
    check("reset test_done", 32'(tdone[0]), 32'd0);
    check("reset test_pass", 32'(tpass[0]), 32'd0);
    check("reset bus_err",   32'(berr[0]), 32'd0);

    // 1: no-wait store/load at top RAM word
    xact(0, 32'h0000_03FC, 32'h1234_5678, 4'hF, rd, lat);
    check("sw latency", 32'(lat), 32'd2);
    xact(0, 32'h0000_03FC, 32'h0, 4'h0, rd, lat);
    check("lw latency", 32'(lat), 32'd2);
    check("lw 0x3FC data", rd, 32'h1234_5678);

    // 2: byte-lane write
    xact(0, 32'h0000_0040, 32'h1122_3344, 4'hF, rd, lat);
    xact(0, 32'h0000_0040, 32'h00AB_0000, 4'b0100, rd, lat);
    check("partial write pre-data", rd, 32'h1122_3344);
    xact(0, 32'h0000_0040, 32'h0, 4'h0, rd, lat);
    check("byte lane merge", rd, 32'h11AB_3344);

    // 4: console and TEST
    xact(0, 32'h1000_0000, 32'h0000_0041, 4'hF, rd, lat);
    check("console data", 32'(cdata[0]), 32'h41);
    check("console pulses", 32'(con_pulses), 32'd1);
    xact(0, 32'h1000_0004, 32'd1, 4'hF, rd, lat);
    xact(0, 32'h1000_0004, 32'd2, 4'hF, rd, lat);
    xact(0, 32'h1000_0004, 32'd0, 4'h0, rd, lat);
    check("TEST read", rd, 32'h3);
    check("test_done", 32'(tdone[0]), 32'd1);
    check("test_pass", 32'(tpass[0]), 32'd1);

    // 5: unmapped, reserved, cycle counter
    check("bus_err before", 32'(berr[0]), 32'd0);
    xact(0, 32'h2000_0000, 32'h0, 4'h0, rd, lat);
    check("unmapped rdata", rd, 32'h0);
    check("bus_err set", 32'(berr[0]), 32'd1);
    xact(0, 32'h0000_03FC, 32'h0, 4'h0, rd, lat);
    check("bus_err sticky", 32'(berr[0]), 32'd1);
    xact(0, 32'h1000_000C, 32'h0, 4'h0, rd, lat);
    check("reserved rdata", rd, 32'h0);
    xact(0, 32'h1000_0008, 32'h0, 4'h0, c1, lat);
    repeat (10) @(posedge clk);
    xact(0, 32'h1000_0008, 32'h0, 4'h0, c2, lat);
    check("cycle delta", c2 - c1, 32'd14);

    // 3: fixed three wait states
    xact(1, 32'h0000_0100, 32'hA5A5_5A5A, 4'hF, rd, lat);
    check("fixed wait sw latency", 32'(lat), 32'd5);
    xact(1, 32'h0000_0100, 32'h0, 4'h0, rd, lat);
    check("fixed wait lw latency", 32'(lat), 32'd5);
    check("fixed wait lw data", rd, 32'hA5A5_5A5A);

    // 6: reset lands on the edge that would commit a write to 0x10
    xact(1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, rd, lat);
    xact(1, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
    @(posedge clk); #1;
    valid[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'hDEAD_BEEF; wstrb[1] = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    rst[1] = 1'b1; valid[1] = 1'b0; wstrb[1] = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 1'b0;
    check("abort mem_ready", 32'(ready[1]), 32'd0);
    check("abort mem_rdata", rdata[1], 32'd0);
    check("abort con_data",  32'(cdata[1]), 32'd0);
    check("abort bus_err",   32'(berr[1]), 32'd0);
    xact(1, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
    check("abort word unchanged", rd, 32'hCAFE_F00D);

    // 3: random wait states
    for (int i = 0; i < 1000; i++) begin
      if (i < 32) begin
        a = 32'(i * 4); wd = $urandom; ws = 4'hF;
      end else begin
        a  = 32'($urandom_range(0, 31) * 4);
        wd = $urandom;
        ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      xact(2, a, wd, ws, rd, lat);
      if (i == 0) check("lfsr first latency", 32'(lat), 32'd3);
      if (i == 1) check("lfsr second latency", 32'(lat), 32'd2);
      check("random latency range", 32'(lat >= 2 && lat <= 5), 32'd1);
      if (lat >= 2 && lat <= 5) hist[lat]++;
    end
    for (int k = 2; k <= 5; k++) check($sformatf("latency %0d seen", k), 32'(hist[k] != 0), 32'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
